iob_split_n: RTL and testbench
==============================

IOB_SPLIT_N -- requirements
Module: iob_split_n

Interface
REQ-001 Parameter N_SLAVES, default 2: number of slave ports, 2..16.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter DATA_W, default 32: data width. Strobe width is DATA_W/8.
REQ-004 Parameter SEL_MODE, default 0. 0 selects the slave from address MSBs. 1 routes instruction fetches to slave 0 and selects data accesses from address MSBs.
REQ-005 Parameter SEL_W, default 1: number of address MSBs used as the slave index. 2^SEL_W SHALL be >= N_SLAVES.
REQ-006 Parameter TIMEOUT, default 255: cycles to wait for s_ready before an error completion. 0 disables the timeout.
REQ-007 Ports:
- clk  in  1  system clock. One clock; every register on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- m_valid  in  1  master request, held until m_ready.
- m_instr  in  1  instruction-fetch flag, used only when SEL_MODE=1.
- m_addr  in  ADDR_W  request address.
- m_wdata  in  DATA_W  write data.
- m_wstrb  in  DATA_W/8  byte strobes; all zero means read.
- m_rdata  out  DATA_W  read data.
- m_ready  out  1  one-cycle completion pulse.
- s_valid  out  N_SLAVES  per-slave request.
- s_addr  out  N_SLAVES*ADDR_W  per-slave address, slave k at slice k.
- s_wdata  out  N_SLAVES*DATA_W  per-slave write data.
- s_wstrb  out  N_SLAVES*DATA_W/8  per-slave strobes.
- s_rdata  in  N_SLAVES*DATA_W  per-slave read data.
- s_ready  in  N_SLAVES  per-slave completion.
- err  out  1  sticky error flag.
- err_addr  out  ADDR_W  address of the first error.

Function
REQ-008 The FSM SHALL have three states: IDLE, ACTIVE, ERR.
REQ-009 In IDLE with m_valid=1, the block SHALL register the slave index, address, wdata and wstrb. If the index < N_SLAVES it goes to ACTIVE; otherwise it goes to ERR.
REQ-010 The slave index SHALL be m_addr[ADDR_W-1 -: SEL_W]. When SEL_MODE=1 and m_instr=1, the index SHALL be 0.
REQ-011 In ACTIVE, s_valid SHALL be 1 only at the registered index, with the registered payload. Request latency is m_valid to s_valid = 1 cycle.
REQ-012 In ACTIVE, when s_ready[idx]=1, m_ready SHALL be 1 in the same cycle, combinationally, and m_rdata = s_rdata[idx]. The FSM then returns to IDLE, and s_valid drops on the next cycle.
REQ-013 s_ready from non-selected slaves SHALL be ignored.
REQ-014 In ERR, m_ready SHALL be 1 for exactly one cycle with m_rdata=0, then the FSM returns to IDLE.
REQ-015 On entry to ERR, err SHALL set if clear. err_addr SHALL be captured only when err was clear.
REQ-016 Timeout: a counter SHALL clear on ACTIVE entry and increment every ACTIVE cycle. When TIMEOUT is nonzero and the counter reaches TIMEOUT without s_ready, the FSM SHALL go to ERR and s_valid SHALL drop.
REQ-017 If s_ready arrives in the same cycle as the timeout, the slave response SHALL win and no error is raised.
REQ-018 In IDLE and ERR, s_valid SHALL be all zeros and m_ready SHALL be 0 except as stated in REQ-014. m_rdata SHALL be 0 whenever m_ready=0.
REQ-019 Requests SHALL be accepted only in IDLE, so at most one transaction is outstanding.
REQ-020 Back-to-back operation: after an m_ready cycle, a new m_valid in the following IDLE cycle SHALL be accepted.
REQ-021 m_addr changes while a transaction is ACTIVE SHALL have no effect on routing.

Reset
REQ-022 While rst=1, the FSM SHALL be IDLE, the counter 0, s_valid 0, m_ready 0, m_rdata 0, err 0, err_addr 0 and all registered payloads 0.
REQ-023 Reset mid-transaction SHALL abort it: s_valid is 0 in the cycle after rst, and no m_ready is issued for the aborted request.
REQ-024 err SHALL clear only on reset.

Structure
REQ-025 FSM state encodings and the error rdata constant (0) SHALL live in the shared interconnect package/header, alongside the existing bus-width macros.
REQ-026 The timeout counter SHALL be a sub-module, iob_split_timer (clear, enable, expire), with width $clog2(TIMEOUT+1).
REQ-027 All other logic SHALL be flat in iob_split_n. The slave muxes SHALL be generate loops.

Verification
REQ-028 N_SLAVES=4, SEL_W=2: read at 0x8000_0010 with slave 2 ready after 3 cycles returning 0x1234_5678 -> only s_valid[2] rises at cycle 1; m_ready at cycle 4 with m_rdata=0x1234_5678.
REQ-029 SEL_MODE=1: m_instr=1 at 0xC000_0000 -> slave 0 selected. The same address with m_instr=0 -> slave 3.
REQ-030 N_SLAVES=3, SEL_W=2: access at 0xC000_0004 -> no s_valid; m_ready one cycle later with rdata 0; err=1 and err_addr=0xC000_0004. A second error leaves err_addr unchanged.
REQ-031 TIMEOUT=8, slave never ready -> m_ready with rdata 0 at cycle 10, err=1. Repeat with s_ready at the expiry cycle -> normal data, err stays 0.
REQ-032 rst asserted two cycles into ACTIVE -> s_valid=0 the next cycle, no m_ready, and a fresh request afterwards completes normally.
REQ-033 Write 0xAABB_CCDD with wstrb=0xF to slave 1, immediately followed by a read from slave 0 -> payloads arrive intact at the correct slices, and the responses complete in order.

Source files
------------

// File: rtl/iob_split_n_pkg.sv
// Shared interconnect definitions: bus-width defaults, split FSM state encoding,
// the read data returned on error completions, and a timer width helper.
package iob_split_n_pkg;

  localparam int IOB_ADDR_W_DEF = 32;
  localparam int IOB_DATA_W_DEF = 32;
  localparam int IOB_MAX_SLAVES = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERR    = 2'd2
  } split_state_t;

  // Every bit of an error completion's read data takes this value.
  localparam logic ERR_RDATA_BIT = 1'b0;

  // A timeout of 0 disables the timer, but the counter still needs one bit.
  function automatic int timer_width(input int limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/iob_split_timer.sv
// Transaction timeout counter: cleared when a transaction starts, counts active
// cycles, and flags expiry once the count reaches LIMIT (never when LIMIT is 0).
module iob_split_timer #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign expire = (LIMIT != 0) && (count_reg == WIDTH'(LIMIT));

endmodule

// File: rtl/iob_split_n.sv
// One-master to N-slave request splitter with address-based routing, one
// outstanding transaction, a response timeout and a sticky error record.
module iob_split_n
  import iob_split_n_pkg::*;
#(
  parameter int N_SLAVES = 2,
  parameter int ADDR_W   = IOB_ADDR_W_DEF,
  parameter int DATA_W   = IOB_DATA_W_DEF,
  parameter int SEL_MODE = 0,
  parameter int SEL_W    = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_valid,
  input  logic                         m_instr,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  input  logic [DATA_W/8-1:0]          m_wstrb,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_ready,
  output logic [N_SLAVES-1:0]          s_valid,
  output logic [N_SLAVES*ADDR_W-1:0]   s_addr,
  output logic [N_SLAVES*DATA_W-1:0]   s_wdata,
  output logic [N_SLAVES*DATA_W/8-1:0] s_wstrb,
  input  logic [N_SLAVES*DATA_W-1:0]   s_rdata,
  input  logic [N_SLAVES-1:0]          s_ready,
  output logic                         err,
  output logic [ADDR_W-1:0]            err_addr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = timer_width(TIMEOUT);

  split_state_t        state_reg;
  logic [SEL_W-1:0]    idx_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [STRB_W-1:0]   wstrb_reg;
  logic [N_SLAVES-1:0] s_valid_reg;
  logic                err_reg;
  logic [ADDR_W-1:0]   err_addr_reg;

  logic [SEL_W-1:0]    idx_next;
  logic                idx_ok;
  logic [N_SLAVES-1:0] sel_ready;
  logic                hit;
  logic                enter_active;
  logic                expire;
  logic [DATA_W-1:0]   rdata_masked [N_SLAVES];
  logic [DATA_W-1:0]   rdata_mux;

  // Instruction fetches bypass address decode when SEL_MODE is 1.
  always_comb begin
    idx_next = m_addr[ADDR_W-1 -: SEL_W];
    if (SEL_MODE == 1 && m_instr) begin
      idx_next = '0;
    end
  end

  assign idx_ok       = (32'(idx_next) < 32'(N_SLAVES));
  assign enter_active = (state_reg == ST_IDLE) && m_valid && idx_ok;

  iob_split_timer #(
    .WIDTH (CNT_W),
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (enter_active),
    .enable (state_reg == ST_ACTIVE),
    .expire (expire)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_SLAVES; gi++) begin : g_slave
      assign s_valid[gi] = s_valid_reg[gi] & ~rst;
      assign s_addr[gi*ADDR_W +: ADDR_W]  = s_valid_reg[gi] ? addr_reg  : '0;
      assign s_wdata[gi*DATA_W +: DATA_W] = s_valid_reg[gi] ? wdata_reg : '0;
      assign s_wstrb[gi*STRB_W +: STRB_W] = s_valid_reg[gi] ? wstrb_reg : '0;
      // Only the routed slave can complete the transaction.
      assign sel_ready[gi] = (state_reg == ST_ACTIVE) && (idx_reg == SEL_W'(gi)) && s_ready[gi];
      assign rdata_masked[gi] = sel_ready[gi] ? s_rdata[gi*DATA_W +: DATA_W] : '0;
    end
  endgenerate

  always_comb begin
    rdata_mux = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      rdata_mux = rdata_mux | rdata_masked[i];
    end
  end

  assign hit      = |sel_ready;
  assign m_ready  = ~rst & (hit | (state_reg == ST_ERR));
  assign m_rdata  = rst ? '0 :
                    (state_reg == ST_ERR) ? {DATA_W{ERR_RDATA_BIT}} : rdata_mux;
  assign err      = err_reg;
  assign err_addr = err_addr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
      s_valid_reg  <= '0;
      err_reg      <= 1'b0;
      err_addr_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (m_valid) begin
            idx_reg   <= idx_next;
            addr_reg  <= m_addr;
            wdata_reg <= m_wdata;
            wstrb_reg <= m_wstrb;
            if (idx_ok) begin
              state_reg   <= ST_ACTIVE;
              s_valid_reg <= N_SLAVES'(1) << idx_next;
            end else begin
              state_reg <= ST_ERR;
              if (!err_reg) begin
                err_reg      <= 1'b1;
                err_addr_reg <= m_addr;
              end
            end
          end
        end
        ST_ACTIVE: begin
          // A response in the expiry cycle still wins over the timeout.
          if (hit) begin
            state_reg   <= ST_IDLE;
            s_valid_reg <= '0;
          end else if (expire) begin
            state_reg   <= ST_ERR;
            s_valid_reg <= '0;
            if (!err_reg) begin
              err_reg      <= 1'b1;
              err_addr_reg <= addr_reg;
            end
          end
        end
        ST_ERR: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg   <= ST_IDLE;
          s_valid_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iob_split_n.sv
// Self-checking bench for iob_split_n (3 slaves, 2 select bits, instruction
// routing, timeout 8) against a cycle-count reference model of each transaction.
`timescale 1ns/1ps
module tb_iob_split_n;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam int SM = 1;
  localparam int TO = 8;
  localparam int BW = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            m_valid;
  logic            m_instr;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [BW-1:0]   m_wstrb;
  logic [DW-1:0]   m_rdata;
  logic            m_ready;
  logic [N-1:0]    s_valid;
  logic [N*AW-1:0] s_addr;
  logic [N*DW-1:0] s_wdata;
  logic [N*BW-1:0] s_wstrb;
  logic [N*DW-1:0] s_rdata;
  logic [N-1:0]    s_ready;
  logic            err;
  logic [AW-1:0]   err_addr;

  int            checks = 0;
  int            failures = 0;
  logic          err_exp;
  logic [AW-1:0] err_addr_exp;

  iob_split_n #(
    .N_SLAVES (N),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .SEL_MODE (SM),
    .SEL_W    (SW),
    .TIMEOUT  (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m_valid  (m_valid),
    .m_instr  (m_instr),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .m_rdata  (m_rdata),
    .m_ready  (m_ready),
    .s_valid  (s_valid),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_rdata  (s_rdata),
    .s_ready  (s_ready),
    .err      (err),
    .err_addr (err_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Target slave from the routing rules; -1 means no such slave.
  function automatic int model_target(input logic [AW-1:0] addr, input logic instr);
    int idx;
    if (SM == 1 && instr) return 0;
    idx = int'(addr >> (AW - SW));
    return (idx < N) ? idx : -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; m_valid = 1'b0; m_instr = 1'b0; m_addr = '0;
    m_wdata = '0; m_wstrb = '0; s_rdata = '0; s_ready = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_s_valid", s_valid, 0);
    check("rst_m_ready", m_ready, 0);
    check("rst_m_rdata", m_rdata, 0);
    check("rst_err", err, 0);
    check("rst_err_addr", err_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    err_exp = 1'b0;
    err_addr_exp = '0;
  endtask

  // Issue one request and follow it cycle by cycle to its completion.
  task automatic run_txn(input logic [AW-1:0] addr, input logic instr, input logic [DW-1:0] wd,
                         input logic [BW-1:0] ws, input int lat, input logic [DW-1:0] rd,
                         input bit noise);
    int            tgt;
    int            exp_lat;
    bit            ok;
    logic [N-1:0]  tmask;
    logic [N-1:0]  exp_sv;
    logic [DW-1:0] exp_rd;
    int            done_cyc;
    tgt     = model_target(addr, instr);
    ok      = (tgt >= 0) && (lat <= TO);
    exp_lat = (tgt < 0) ? 1 : ((lat <= TO) ? 1 + lat : TO + 2);
    tmask   = (tgt >= 0) ? (N'(1) << tgt) : '0;
    done_cyc = -1;

    m_valid = 1'b1; m_instr = instr; m_addr = addr; m_wdata = wd; m_wstrb = ws;
    for (int k = 0; k < N; k++) s_rdata[k*DW +: DW] = $urandom;
    if (tgt >= 0) s_rdata[tgt*DW +: DW] = rd;
    s_ready = noise ? (N'($urandom) & ~tmask) : '0;
    @(negedge clk);
    check("idle_s_valid", s_valid, 0);
    check("idle_m_ready", m_ready, 0);
    check("idle_err", err, err_exp);
    if (!ok && !err_exp) begin
      err_exp = 1'b1;
      err_addr_exp = addr;
    end
    @(posedge clk); #1;
    m_valid = 1'b0; m_addr = $urandom; m_wdata = $urandom; m_instr = 1'($urandom);

    for (int cyc = 1; cyc <= TO + 3; cyc++) begin
      s_ready = noise ? (N'($urandom) & ~tmask) : '0;
      if (tgt >= 0 && cyc == 1 + lat) s_ready = s_ready | tmask;
      @(negedge clk);
      exp_sv = (cyc <= exp_lat && cyc <= TO + 1) ? tmask : '0;
      check("s_valid", s_valid, exp_sv);
      if (cyc == 1 && tgt >= 0) begin
        check("s_addr", s_addr[tgt*AW +: AW], addr);
        check("s_wdata", s_wdata[tgt*DW +: DW], wd);
        check("s_wstrb", s_wstrb[tgt*BW +: BW], ws);
      end
      check("m_ready", m_ready, (cyc == exp_lat));
      exp_rd = (cyc == exp_lat && ok) ? rd : '0;
      check("m_rdata", m_rdata, exp_rd);
      if (m_ready) done_cyc = cyc;
      if (cyc == exp_lat) begin
        check("err", err, err_exp);
        check("err_addr", err_addr, err_addr_exp);
      end
      @(posedge clk); #1;
      if (cyc == exp_lat) break;
    end
    s_ready = '0;
    $display("txn addr=0x%08h instr=%0d slave=%0d lat=%0d exp_cycle=%0d seen_cycle=%0d rdata=0x%08h err=%0d",
             addr, instr, tgt, lat, exp_lat, done_cyc, exp_rd, err_exp);
  endtask

  initial begin
    logic [AW-1:0] a;
    do_reset();

    // Read from slave 2 that answers 3 cycles after s_valid.
    run_txn(32'h8000_0010, 1'b0, 32'h0, 4'h0, 3, 32'h1234_5678, 1'b0);
    // Write to slave 1, immediately followed by a read from slave 0.
    run_txn(32'h4000_0008, 1'b0, 32'hAABB_CCDD, 4'hF, 2, 32'h0, 1'b1);
    run_txn(32'h0000_0020, 1'b0, 32'h0, 4'h0, 1, 32'hCAFE_0001, 1'b1);
    // Instruction fetch from the top of the map routes to slave 0.
    run_txn(32'hC000_0000, 1'b1, 32'h0, 4'h0, 0, 32'h0BAD_F00D, 1'b1);
    // Response in the expiry cycle wins; err must stay clear.
    run_txn(32'h8000_0040, 1'b0, 32'h0, 4'h0, TO, 32'h5555_AAAA, 1'b0);

    for (int t = 0; t < 30; t++) begin
      a = $urandom;
      a[AW-1 -: SW] = SW'($urandom_range(0, N - 1));
      run_txn(a, 1'($urandom), $urandom, BW'($urandom), $urandom_range(0, TO), $urandom, 1'b1);
    end
    check("err_after_valid", err, 0);

    // Data access to the unpopulated index, then a second error.
    run_txn(32'hC000_0000, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b1);
    do_reset();
    run_txn(32'hC000_0004, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0);
    run_txn(32'hC000_0100, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b1);
    check("err_addr_sticky", err_addr, 32'hC000_0004);

    // Slave that never answers times out.
    do_reset();
    run_txn(32'h4000_0044, 1'b0, 32'h0, 4'h0, 100, 32'h0, 1'b0);

    // Reset two cycles into an active transaction.
    do_reset();
    m_valid = 1'b1; m_instr = 1'b0; m_addr = 32'h4000_0100; m_wstrb = '0;
    @(posedge clk); #1;
    m_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      check("abort_s_valid_pre", s_valid, 3'b010);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    s_ready = 3'b010;
    s_rdata[1*DW +: DW] = 32'hDEAD_BEEF;
    @(negedge clk);
    check("abort_m_ready_in_rst", m_ready, 0);
    check("abort_m_rdata_in_rst", m_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_s_valid_after", s_valid, 0);
    check("abort_m_ready_after", m_ready, 0);
    check("abort_err", err, 0);
    @(posedge clk); #1;
    s_ready = '0;
    err_exp = 1'b0;
    err_addr_exp = '0;
    run_txn(32'h4000_0104, 1'b0, 32'h0, 4'h0, 2, 32'h7777_1111, 1'b0);

    for (int t = 0; t < 30; t++) begin
      run_txn($urandom, 1'($urandom), $urandom, BW'($urandom), $urandom_range(0, TO + 3),
              $urandom, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
